// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, memory-stage and backend signal bundle for mem_port_arbiter
interface mem_port_arbiter_if;
   // fetch port
   logic        f_req;
   logic [63:0] f_addr;
   logic        f_ack;
   logic [63:0] f_rdata;
   logic        f_err;

   // memory-stage port
   logic        m_req;
   logic        m_we;
   logic [63:0] m_addr;
   logic [63:0] m_wdata;
   logic        m_ack;
   logic [63:0] m_rdata;
   logic        m_err;

   // backend
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_rdy;

   // status
   logic        busy;

   // requesters and backend model drive the arbiter inputs
   modport master (
      output f_req, f_addr,
      output m_req, m_we, m_addr, m_wdata,
      output mem_rdata, mem_rdy,
      input  f_ack, f_rdata, f_err,
      input  m_ack, m_rdata, m_err,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  busy
   );

   // arbiter view
   modport slave (
      input  f_req, f_addr,
      input  m_req, m_we, m_addr, m_wdata,
      input  mem_rdata, mem_rdy,
      output f_ack, f_rdata, f_err,
      output m_ack, m_rdata, m_err,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter onto one backend memory port
module mem_port_arbiter #(
   parameter logic [63:0] ADDR_LIMIT = 64'd4095,
   parameter int unsigned TIMEOUT    = 15
) (
   input logic               clock,
   input logic               reset_n,
   mem_port_arbiter_if.slave bus
);
   // counter holds 0..TIMEOUT-1; the last value is the timeout cycle
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   logic             last_owner_m;   // 1 when the memory-stage port won the previous grant
   logic             owner_m;        // owner of the transaction in flight
   logic [CNT_W-1:0] busy_cnt;

   logic             grant_m;
   logic             grant_f;
   logic             grant_any;
   logic [63:0]      grant_addr;
   logic             grant_we;
   logic [63:0]      grant_wdata;
   logic             grant_illegal;
   logic             timeout_hit;
   logic [63:0]      done_rdata;

   // grant choice: a lone requester wins, a tie goes to the port not served last
   always_comb begin
      grant_m       = 1'b0;
      grant_f       = 1'b0;
      grant_addr    = 64'd0;
      grant_we      = 1'b0;
      grant_wdata   = 64'd0;
      grant_m       = bus.m_req && (!bus.f_req || !last_owner_m);
      grant_f       = bus.f_req && !grant_m;
      if (grant_m) begin
         grant_addr  = bus.m_addr;
         grant_we    = bus.m_we;
         grant_wdata = bus.m_wdata;
      end else if (grant_f) begin
         grant_addr  = bus.f_addr;
      end
      grant_any     = grant_m || grant_f;
      grant_illegal = grant_addr > ADDR_LIMIT;
   end

   // completion terms for the BUSY state; mem_rdy on the timeout cycle still wins
   always_comb begin
      timeout_hit = (busy_cnt == CNT_W'(TIMEOUT - 1));
      done_rdata  = 64'd0;
      if (bus.mem_rdy && !bus.mem_we) begin
         done_rdata = bus.mem_rdata;
      end
   end

   // arbitration FSM; every port output is a register written here
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         last_owner_m  <= 1'b0;
         owner_m       <= 1'b0;
         busy_cnt      <= '0;
         bus.f_ack     <= 1'b0;
         bus.f_rdata   <= 64'd0;
         bus.f_err     <= 1'b0;
         bus.m_ack     <= 1'b0;
         bus.m_rdata   <= 64'd0;
         bus.m_err     <= 1'b0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= 64'd0;
         bus.mem_wdata <= 64'd0;
         bus.busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  last_owner_m <= grant_m;
                  owner_m      <= grant_m;
                  bus.busy     <= 1'b1;
                  if (grant_illegal) begin
                     // out-of-range address never reaches the backend
                     state       <= RESP;
                     bus.m_ack   <= grant_m;
                     bus.m_err   <= grant_m;
                     bus.m_rdata <= 64'd0;
                     bus.f_ack   <= grant_f;
                     bus.f_err   <= grant_f;
                     bus.f_rdata <= 64'd0;
                  end else begin
                     state         <= BUSY;
                     busy_cnt      <= '0;
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= grant_we;
                     bus.mem_addr  <= grant_addr;
                     bus.mem_wdata <= grant_wdata;
                  end
               end
            end

            BUSY: begin
               if (bus.mem_rdy || timeout_hit) begin
                  state         <= RESP;
                  bus.mem_req   <= 1'b0;
                  bus.mem_we    <= 1'b0;
                  bus.mem_addr  <= 64'd0;
                  bus.mem_wdata <= 64'd0;
                  bus.m_ack     <= owner_m;
                  bus.m_err     <= owner_m && !bus.mem_rdy;
                  bus.m_rdata   <= owner_m ? done_rdata : 64'd0;
                  bus.f_ack     <= !owner_m;
                  bus.f_err     <= !owner_m && !bus.mem_rdy;
                  bus.f_rdata   <= owner_m ? 64'd0 : done_rdata;
               end else begin
                  busy_cnt <= busy_cnt + 1'b1;
               end
            end

            RESP: begin
               // single-cycle pulse, then back to fresh arbitration
               state       <= IDLE;
               bus.busy    <= 1'b0;
               bus.f_ack   <= 1'b0;
               bus.f_rdata <= 64'd0;
               bus.f_err   <= 1'b0;
               bus.m_ack   <= 1'b0;
               bus.m_rdata <= 64'd0;
               bus.m_err   <= 1'b0;
            end

            default: begin
               state       <= IDLE;
               bus.busy    <= 1'b0;
               bus.mem_req <= 1'b0;
               bus.f_ack   <= 1'b0;
               bus.m_ack   <= 1'b0;
            end
         endcase
      end
   end

   // the two acknowledges are mutually exclusive
   a_ack_onehot: assert property (@(posedge clock) disable iff (!reset_n)
      !(bus.f_ack && bus.m_ack));

   // a backend request only exists while busy
   a_req_in_busy: assert property (@(posedge clock) disable iff (!reset_n)
      bus.mem_req |-> bus.busy);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   always #5 clock = ~clock;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(
      .ADDR_LIMIT (64'd4095),
      .TIMEOUT    (15)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // backend model: returns addr + 0x1A on BUSY cycle rdy_cycle (0 = never)
   int          rdy_cycle   = 1;
   int          busy_k      = 0;
   logic        model_rdy   = 1'b0;
   logic        stray_rdy   = 1'b0;
   logic [63:0] model_rdata = 64'd0;

   assign bus.mem_rdy   = model_rdy | stray_rdy;
   assign bus.mem_rdata = model_rdata;

   // backend responder, driven away from the active edge
   always @(negedge clock) begin
      if (bus.mem_req) begin
         busy_k = busy_k + 1;
         if (rdy_cycle != 0 && busy_k == rdy_cycle) begin
            model_rdy   = 1'b1;
            model_rdata = bus.mem_addr + 64'h1A;
         end else begin
            model_rdy   = 1'b0;
            model_rdata = 64'd0;
         end
      end else begin
         busy_k      = 0;
         model_rdy   = 1'b0;
         model_rdata = 64'd0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // one request on one port, checked for latency, backend activity and response
   task automatic txn(input string tag, input bit port_m, input bit we,
                      input logic [63:0] addr, input logic [63:0] wdata,
                      input int rdy_at, input int exp_lat, input int exp_req_cycles,
                      input logic [63:0] exp_rdata, input logic exp_err);
      int          lat;
      int          req_cycles;
      bit          seen;
      logic [63:0] got_rdata;
      logic        got_err;
      logic        other_ack;
      logic [63:0] seen_addr;
      logic        seen_we;
      logic [63:0] seen_wdata;
      lat        = 0;
      req_cycles = 0;
      seen       = 1'b0;
      got_rdata  = 64'd0;
      got_err    = 1'b0;
      other_ack  = 1'b0;
      seen_addr  = 64'd0;
      seen_we    = 1'b0;
      seen_wdata = 64'd0;
      rdy_cycle  = rdy_at;
      @(negedge clock);
      if (port_m) begin
         bus.m_req   = 1'b1;
         bus.m_we    = we;
         bus.m_addr  = addr;
         bus.m_wdata = wdata;
      end else begin
         bus.f_req  = 1'b1;
         bus.f_addr = addr;
      end
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clock);
         lat++;
         if (bus.mem_req) begin
            if (req_cycles == 0) begin
               seen_addr  = bus.mem_addr;
               seen_we    = bus.mem_we;
               seen_wdata = bus.mem_wdata;
            end
            req_cycles++;
         end
         if (port_m ? bus.m_ack : bus.f_ack) begin
            seen      = 1'b1;
            got_rdata = port_m ? bus.m_rdata : bus.f_rdata;
            got_err   = port_m ? bus.m_err : bus.f_err;
            other_ack = port_m ? bus.f_ack : bus.m_ack;
            bus.m_req = 1'b0;
            bus.f_req = 1'b0;
         end
      end
      bus.m_req = 1'b0;
      bus.f_req = 1'b0;
      check({tag, "_acked"},     64'(seen),       64'd1);
      check({tag, "_latency"},   64'(lat),        64'(exp_lat));
      check({tag, "_req_cycles"},64'(req_cycles), 64'(exp_req_cycles));
      check({tag, "_rdata"},     got_rdata,       exp_rdata);
      check({tag, "_err"},       64'(got_err),    64'(exp_err));
      check({tag, "_other_ack"}, 64'(other_ack),  64'd0);
      if (exp_req_cycles > 0) begin
         check({tag, "_mem_addr"}, seen_addr,      addr);
         check({tag, "_mem_we"},   64'(seen_we),   64'(port_m && we));
         if (port_m && we) check({tag, "_mem_wdata"}, seen_wdata, wdata);
      end
      @(negedge clock);
      check({tag, "_busy_after"},  64'(bus.busy),               64'd0);
      check({tag, "_ack_after"},   64'(bus.f_ack | bus.m_ack),  64'd0);
      check({tag, "_rdata_after"}, bus.f_rdata | bus.m_rdata,   64'd0);
      check({tag, "_err_after"},   64'(bus.f_err | bus.m_err),  64'd0);
   endtask

   // stop a runaway run with a visible failure
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   logic [63:0] rr_exp_rdata [4] = '{64'h21A, 64'h11A, 64'h22A, 64'h12A};
   logic        rr_exp_m     [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      logic [63:0] rr_rdata [4];
      logic        rr_m     [4];
      int          n_done;
      int          f_cnt;
      int          m_cnt;
      int          both;
      int          acks;

      // both ports request while reset is held
      bus.f_req   = 1'b1;
      bus.f_addr  = 64'h100;
      bus.m_req   = 1'b1;
      bus.m_we    = 1'b0;
      bus.m_addr  = 64'h200;
      bus.m_wdata = 64'd0;
      rdy_cycle   = 1;
      #1;
      check("reset_busy",    64'(bus.busy),    64'd0);
      check("reset_mem_req", 64'(bus.mem_req), 64'd0);
      check("reset_acks",    64'(bus.f_ack | bus.m_ack), 64'd0);
      check("reset_mem_addr",bus.mem_addr,     64'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      // round-robin: each port re-requests straight after its first ack
      n_done = 0;
      f_cnt  = 0;
      m_cnt  = 0;
      both   = 0;
      for (int c = 0; c < 80 && n_done < 4; c++) begin
         @(negedge clock);
         if (bus.f_ack && bus.m_ack) both++;
         if (bus.m_ack) begin
            rr_m[n_done]     = 1'b1;
            rr_rdata[n_done] = bus.m_rdata;
            n_done++;
            m_cnt++;
            if (m_cnt == 2) bus.m_req = 1'b0;
            else            bus.m_addr = 64'h210;
         end else if (bus.f_ack) begin
            rr_m[n_done]     = 1'b0;
            rr_rdata[n_done] = bus.f_rdata;
            n_done++;
            f_cnt++;
            if (f_cnt == 2) bus.f_req = 1'b0;
            else            bus.f_addr = 64'h110;
         end
      end
      bus.f_req = 1'b0;
      bus.m_req = 1'b0;
      check("rr_grants", 64'(n_done), 64'd4);
      check("rr_both_ack", 64'(both), 64'd0);
      for (int k = 0; k < 4; k++) begin
         if (k < n_done) begin
            check($sformatf("rr_owner%0d", k), 64'(rr_m[k]), 64'(rr_exp_m[k]));
            check($sformatf("rr_rdata%0d", k), rr_rdata[k],  rr_exp_rdata[k]);
         end
      end
      @(negedge clock);

      //   tag          m   we  addr          wdata        rdy lat req rdata     err
      txn("m_rd_10",    1, 0, 64'h10,       64'h0,       1,  2,  1,  64'h2A,   1'b0);
      txn("m_wr_4096",  1, 1, 64'd4096,     64'h55,      1,  1,  0,  64'h0,    1'b1);
      txn("m_wr_4095",  1, 1, 64'd4095,     64'hDEAD,    3,  4,  3,  64'h0,    1'b0);
      txn("f_timeout",  0, 0, 64'h20,       64'h0,       0,  16, 15, 64'h0,    1'b1);
      txn("f_rdy_15",   0, 0, 64'h40,       64'h0,       15, 16, 15, 64'h5A,   1'b0);
      txn("f_bad_addr", 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 1, 0, 64'h0, 1'b1);

      // stray mem_rdy while idle is ignored
      @(negedge clock);
      stray_rdy = 1'b1;
      repeat (2) @(negedge clock);
      stray_rdy = 1'b0;
      check("stray_busy", 64'(bus.busy), 64'd0);
      check("stray_acks", 64'(bus.f_ack | bus.m_ack), 64'd0);

      // reset while a fetch waits in BUSY
      rdy_cycle  = 0;
      bus.f_addr = 64'h30;
      bus.f_req  = 1'b1;
      repeat (3) @(negedge clock);
      check("inflight_busy",    64'(bus.busy),    64'd1);
      check("inflight_mem_req", 64'(bus.mem_req), 64'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check("async_rst_mem_req", 64'(bus.mem_req), 64'd0);
      check("async_rst_busy",    64'(bus.busy),    64'd0);
      bus.f_req = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      acks = 0;
      repeat (6) begin
         @(negedge clock);
         if (bus.f_ack || bus.m_ack) acks++;
      end
      check("abandoned_no_ack", 64'(acks), 64'd0);

      txn("f_after_rst", 0, 0, 64'h8,       64'h0,       2,  3,  2,  64'h22,   1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
